// File: rtl/pc_ctrl_pkg.sv
// Shared types for the fetch PC sequencer: FSM states, redirect sources, flush vector.
package pc_ctrl_pkg;

  localparam int unsigned INST_ADDR_BUS = 32;
  localparam logic [INST_ADDR_BUS-1:0] CPU_RESET_ADDR = '0;

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_TRAP} pc_ctrl_state_e;

  // Numeric encoding doubles as priority: higher value wins.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_JMP  = 2'd1,
    SRC_BR   = 2'd2,
    SRC_TRAP = 2'd3
  } redir_src_e;

  typedef struct packed {
    logic f_if;
    logic f_id;
    logic f_ex;
  } flush_t;

  function automatic flush_t flush_for(input redir_src_e src);
    flush_t f;
    f = '0;
    case (src)
      SRC_TRAP: begin f.f_if = 1'b1; f.f_id = 1'b1; f.f_ex = 1'b1; end
      SRC_BR:   begin f.f_if = 1'b1; f.f_id = 1'b1; end
      SRC_JMP:  f.f_if = 1'b1;
      default:  f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational 3-way priority pick (trap > br > jmp) yielding source, target and flushes.
module pc_redirect_arb
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = INST_ADDR_BUS
) (
  input  logic              trap_req,
  input  logic [ADDR_W-1:0] trap_target,
  input  logic              br_req,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp_req,
  input  logic [ADDR_W-1:0] jmp_target,
  output redir_src_e        src_c,
  output logic [ADDR_W-1:0] target_c,
  output flush_t            flush_c
);

  always_comb begin
    src_c    = SRC_NONE;
    target_c = '0;
    if (trap_req) begin
      src_c    = SRC_TRAP;
      target_c = trap_target;
    end else if (br_req) begin
      src_c    = SRC_BR;
      target_c = br_target;
    end else if (jmp_req) begin
      src_c    = SRC_JMP;
      target_c = jmp_target;
    end
    flush_c = flush_for(src_c);
  end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch PC sequencer: arbitrates redirects vs. stalls and drives hold/load-PC and flushes.
// Optional perf counters are built when PC_CTRL_PERF_EN is defined.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = INST_ADDR_BUS,
  parameter int unsigned CAUSE_W = 4
`ifdef PC_CTRL_PERF_EN
  ,
  parameter int unsigned PERF_W  = 32
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic               stall_req,
  input  logic               jmp_req,
  input  logic [ADDR_W-1:0]  jmp_target,
  input  logic               br_req,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               trap_req,
  input  logic [CAUSE_W-1:0] trap_cause,
  input  logic [ADDR_W-1:0]  trap_epc,
  input  logic [ADDR_W-1:0]  mtvec,
  output logic               hold_o,
  output logic [ADDR_W-1:0]  pc_next_o,
  output logic               flush_if_o,
  output logic               flush_id_o,
  output logic               flush_ex_o,
  output logic               trap_ack_o,
  output logic [ADDR_W-1:0]  epc_o,
  output logic [CAUSE_W-1:0] cause_o
`ifdef PC_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]  redirect_cnt_o,
  output logic [PERF_W-1:0]  stall_cnt_o
`endif
);

  pc_ctrl_state_e    state_q, state_d;
  redir_src_e        pend_src_q, pend_src_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              cap;

  redir_src_e        live_src, merge_src;
  logic [ADDR_W-1:0] live_tgt, merge_tgt;
  flush_t            live_flush, merge_flush;
  logic              latch_ok;

  pc_redirect_arb #(.ADDR_W(ADDR_W)) u_live_arb (
    .trap_req    (trap_req),
    .trap_target (mtvec),
    .br_req      (br_req),
    .br_target   (br_target),
    .jmp_req     (jmp_req),
    .jmp_target  (jmp_target),
    .src_c       (live_src),
    .target_c    (live_tgt),
    .flush_c     (live_flush)
  );

  // Pending redirect vs. this cycle's winner; at equal class the live target is newer.
  pc_redirect_arb #(.ADDR_W(ADDR_W)) u_merge_arb (
    .trap_req    ((live_src == SRC_TRAP) || (pend_src_q == SRC_TRAP)),
    .trap_target ((live_src == SRC_TRAP) ? live_tgt : pend_tgt_q),
    .br_req      ((live_src == SRC_BR) || (pend_src_q == SRC_BR)),
    .br_target   ((live_src == SRC_BR) ? live_tgt : pend_tgt_q),
    .jmp_req     ((live_src == SRC_JMP) || (pend_src_q == SRC_JMP)),
    .jmp_target  ((live_src == SRC_JMP) ? live_tgt : pend_tgt_q),
    .src_c       (merge_src),
    .target_c    (merge_tgt),
    .flush_c     (merge_flush)
  );

  assign latch_ok = (live_src != SRC_NONE) && (live_src >= pend_src_q);

  always_comb begin
    state_d    = state_q;
    pend_src_d = pend_src_q;
    pend_tgt_d = pend_tgt_q;
    cap        = 1'b0;
    hold_o     = 1'b0;
    pc_next_o  = pc_i;
    flush_if_o = 1'b0;
    flush_id_o = 1'b0;
    flush_ex_o = 1'b0;
    trap_ack_o = 1'b0;
    case (state_q)
      ST_RUN: begin
        cap = (live_src == SRC_TRAP);
        if (stall_req) begin
          hold_o = 1'b1;
          if (latch_ok) begin
            pend_src_d = live_src;
            pend_tgt_d = live_tgt;
          end
          state_d = ST_STALL;
        end else if (live_src != SRC_NONE) begin
          hold_o     = 1'b1;
          pc_next_o  = live_tgt;
          flush_if_o = live_flush.f_if;
          flush_id_o = live_flush.f_id;
          flush_ex_o = live_flush.f_ex;
          if (live_src == SRC_TRAP) state_d = ST_TRAP;
        end
      end
      ST_STALL: begin
        cap = (live_src == SRC_TRAP);
        if (stall_req) begin
          hold_o = 1'b1;
          if (latch_ok) begin
            pend_src_d = live_src;
            pend_tgt_d = live_tgt;
          end
        end else begin
          pend_src_d = SRC_NONE;
          pend_tgt_d = '0;
          state_d    = (merge_src == SRC_TRAP) ? ST_TRAP : ST_RUN;
          if (merge_src != SRC_NONE) begin
            hold_o     = 1'b1;
            pc_next_o  = merge_tgt;
            flush_if_o = merge_flush.f_if;
            flush_id_o = merge_flush.f_id;
            flush_ex_o = merge_flush.f_ex;
          end
        end
      end
      ST_TRAP: begin
        // PC already holds mtvec; redirect inputs here come from squashed instructions.
        trap_ack_o = 1'b1;
        hold_o     = 1'b1;
        flush_id_o = 1'b1;
        flush_ex_o = 1'b1;
        state_d    = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (!rst_n) begin
      hold_o     = 1'b0;
      pc_next_o  = ADDR_W'(CPU_RESET_ADDR);
      flush_if_o = 1'b1;
      flush_id_o = 1'b1;
      flush_ex_o = 1'b1;
      trap_ack_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pend_src_q <= SRC_NONE;
      pend_tgt_q <= '0;
      epc_o      <= '0;
      cause_o    <= '0;
    end else begin
      state_q    <= state_d;
      pend_src_q <= pend_src_d;
      pend_tgt_q <= pend_tgt_d;
      if (cap) begin
        epc_o   <= trap_epc;
        cause_o <= trap_cause;
      end
    end
  end

`ifdef PC_CTRL_PERF_EN
  // Every applied redirect flushes IF; the TRAP cycle does not, so this counts redirects only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt_o <= '0;
      stall_cnt_o    <= '0;
    end else begin
      if (flush_if_o) redirect_cnt_o <= redirect_cnt_o + PERF_W'(1);
      if (stall_req)  stall_cnt_o    <= stall_cnt_o + PERF_W'(1);
    end
  end
`endif

endmodule
